execute: RTL and testbench
==========================

// Module: execute
// PURPOSE
//  EX stage of the 5-stage RV32I pipeline; consumes the ID/EX register outputs driven by decode.
//  Forwards operands, runs ALU, resolves branches/jumps, drives redirect to fetch.
//  Registers results into EX/MEM for the memory stage. Pure 1-cycle stage, no stalls.
// PARAMETERS
//  XLEN       32  datapath width (only 32 supported)
//  RESET_PC4  0   reset/clear value of pc4M
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     async active-low reset
//  regwriteE, memrwE, brunE, branchE, jumpE, bselE  in 1  ID/EX control bits
//  wbselE      in   2     00 mem, 01 alu, 10 pc+4
//  ALUselE     in   3     000 add, 001 sub, 010 and, 011 or, 100 xor; others -> add
//  funct3E     in   3     branch condition / mem width passthrough
//  rdE, rs1E, rs2E  in 5  register indices
//  rd1E, rd2E, imm_exE, pcE, pc4E  in 32  operands / immediate / pc
//  regwriteW   in   1     WB write enable (forward source)
//  rdW         in   5     WB destination
//  resultW     in   32    WB result
//  pcselE      out  1     redirect fetch this cycle (comb)
//  pctargetE   out  32    redirect target (comb)
//  regwriteM, memrwM  out 1;  wbselM out 2;  funct3M out 3;  rdM out 5
//  aluresultM, writedataM, pc4M  out 32   EX/MEM register outputs
// BEHAVIOUR
//  - Reset (async, rst_n=0): every EX/MEM output = 0 (pc4M = RESET_PC4) immediately; released sync.
//  - EX/MEM register loads every clk edge; latency EX->M = 1 cycle. No enable, no flush input.
//  - Forward A/B (per rs1E/rs2E): M hit if regwriteM && rdM!=0 && rdM==rsX && wbselM!=00;
//    value = pc4M if wbselM==10 else aluresultM. W hit if regwriteW && rdW!=0 && rdW==rsX -> resultW.
//    M and W both hit -> M wins. rsX==0 never forwards. Load in M never forwards (hazard unit stalls).
//  - srcA = fwdA; srcB = bselE ? imm_exE : fwdB; writedataM <= fwdB (always rs2 path, not imm).
//  - ALU 32-bit wrap-around add/sub; undefined ALUselE codes -> add.
//  - Branch compare on fwdA vs fwdB: funct3 000 eq, 001 ne, 100 lt, 101 ge, others never taken;
//    lt/ge signed when brunE=0, unsigned when brunE=1.
//  - pcselE = jumpE | (branchE & cond). Target: jumpE&bselE (jalr) -> (srcA+imm_exE)&~1;
//    otherwise pcE+imm_exE. pctargetE = 0 when pcselE=0.
//  - Bubble from decode flush (all controls 0) -> pcselE=0, regwriteM=memrwM=0 next cycle.
//  - Simultaneous WB write and EX read of same reg is covered by W forward (no RF bypass needed).
// CONFIGURATION
//  EXEC_FWD_EN defined: forwarding network as above.
//  EXEC_FWD_EN undefined: fwdA=rd1E, fwdB=rd2E, no M/W compare logic; hazard unit must stall
//    all RAW hazards; regwriteW/rdW/resultW unused.
// TESTING
//  1. Assert rst_n=0 mid-stream with aluresultM=0x55 -> all M outputs 0 same cycle, stay 0 till edge.
//  2. add x3,x1,x2 rd1E=5 rd2E=7 ALUsel=000 -> next edge aluresultM=12, rdM=3, regwriteM=1, wbselM=01.
//  3. Back-to-back: M holds rd=3 alu=12, W writes x3=99, EX rs1E=3 -> srcA=12 (M priority); rdM=0 -> no fwd.
//  4. blt rd1E=0xFFFFFFFF rd2E=1 brunE=0 pcE=0x100 imm=0x20 -> pcselE=1, pctargetE=0x120; brunE=1 -> pcselE=0.
//  5. jalr rd1E=0x203 imm=4 bselE=1 jumpE=1 -> pctargetE=0x206; pc4M=pc4E, wbselM=10 next edge.
//  6. Load in M (wbselM=00, rdM=5), EX rs1E=5 -> no M forward; W match used if present, else rd1E.

Source files
------------

// File: rtl/execute.sv
// -----------------------------------------------------------------------------
// execute : EX stage of a 5-stage RV32I pipeline.
//
// Takes the ID/EX register outputs from decode, selects operands (optionally
// through a forwarding network), runs the ALU, resolves branches and jumps,
// drives the combinational redirect to fetch, and registers the results into
// the EX/MEM pipeline register. One cycle per instruction, never stalls.
//
// Build option:
//   EXEC_FWD_EN  defined   -> M/W operand forwarding network is built.
//                undefined -> operands come straight from rd1E/rd2E; the
//                             hazard unit must stall every RAW hazard and the
//                             WB inputs (regwriteW/rdW/resultW) are unused.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   i_regwriteE .. i_bselE         ID/EX control bits
//   i_wbselE   [1:0]               00 mem, 01 alu, 10 pc+4
//   i_ALUselE  [2:0]               000 add, 001 sub, 010 and, 011 or, 100 xor
//   i_funct3E  [2:0]               branch condition / mem width
//   i_rdE, i_rs1E, i_rs2E [4:0]    register indices
//   i_rd1E, i_rd2E, i_imm_exE, i_pcE, i_pc4E [XLEN-1:0]
//   i_regwriteW, i_rdW, i_resultW  WB-stage forward source
//   o_pcselE, o_pctargetE          combinational fetch redirect
//   o_regwriteM .. o_pc4M          EX/MEM register outputs
// -----------------------------------------------------------------------------
module execute #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC4 = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_regwriteE,
    input  logic            i_memrwE,
    input  logic            i_brunE,
    input  logic            i_branchE,
    input  logic            i_jumpE,
    input  logic            i_bselE,
    input  logic [1:0]      i_wbselE,
    input  logic [2:0]      i_ALUselE,
    input  logic [2:0]      i_funct3E,
    input  logic [4:0]      i_rdE,
    input  logic [4:0]      i_rs1E,
    input  logic [4:0]      i_rs2E,
    input  logic [XLEN-1:0] i_rd1E,
    input  logic [XLEN-1:0] i_rd2E,
    input  logic [XLEN-1:0] i_imm_exE,
    input  logic [XLEN-1:0] i_pcE,
    input  logic [XLEN-1:0] i_pc4E,
    input  logic            i_regwriteW,
    input  logic [4:0]      i_rdW,
    input  logic [XLEN-1:0] i_resultW,
    output logic            o_pcselE,
    output logic [XLEN-1:0] o_pctargetE,
    output logic            o_regwriteM,
    output logic            o_memrwM,
    output logic [1:0]      o_wbselM,
    output logic [2:0]      o_funct3M,
    output logic [4:0]      o_rdM,
    output logic [XLEN-1:0] o_aluresultM,
    output logic [XLEN-1:0] o_writedataM,
    output logic [XLEN-1:0] o_pc4M
);

    // EX/MEM pipeline registers
    logic            r_regwriteM;
    logic            r_memrwM;
    logic [1:0]      r_wbselM;
    logic [2:0]      r_funct3M;
    logic [4:0]      r_rdM;
    logic [XLEN-1:0] r_aluresultM;
    logic [XLEN-1:0] r_writedataM;
    logic [XLEN-1:0] r_pc4M;

    logic [XLEN-1:0] w_fwdA;
    logic [XLEN-1:0] w_fwdB;
    logic [XLEN-1:0] w_srcB;
    logic [XLEN-1:0] w_alu;
    logic            w_cond;
    logic            w_pcsel;
    logic [XLEN-1:0] w_target;

    // Branch condition: eq/ne/lt/ge, signedness chosen by brun; other codes never taken.
    function automatic logic branch_cond(input logic [2:0]      f3,
                                         input logic            unsgn,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
        logic lt;
        lt = unsgn ? (a < b) : ($signed(a) < $signed(b));
        case (f3)
            3'b000:  return (a == b);
            3'b001:  return (a != b);
            3'b100:  return lt;
            3'b101:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

`ifdef EXEC_FWD_EN
    logic            w_m_hitA;
    logic            w_m_hitB;
    logic            w_w_hitA;
    logic            w_w_hitB;
    logic            w_m_fwd_ok;
    logic [XLEN-1:0] w_m_val;

    // A load in M has no data yet (wbsel 00), so it is never a forward source.
    assign w_m_fwd_ok = r_regwriteM && (r_rdM != 5'd0) && (r_wbselM != 2'b00);
    assign w_m_val    = (r_wbselM == 2'b10) ? r_pc4M : r_aluresultM;
    assign w_m_hitA   = w_m_fwd_ok && (r_rdM == i_rs1E);
    assign w_m_hitB   = w_m_fwd_ok && (r_rdM == i_rs2E);
    assign w_w_hitA   = i_regwriteW && (i_rdW != 5'd0) && (i_rdW == i_rs1E);
    assign w_w_hitB   = i_regwriteW && (i_rdW != 5'd0) && (i_rdW == i_rs2E);

    // Operand forwarding; the younger M result takes priority over W.
    always_comb begin
        w_fwdA = i_rd1E;
        w_fwdB = i_rd2E;
        if (w_m_hitA) begin
            w_fwdA = w_m_val;
        end else if (w_w_hitA) begin
            w_fwdA = i_resultW;
        end else begin
            w_fwdA = i_rd1E;
        end
        if (w_m_hitB) begin
            w_fwdB = w_m_val;
        end else if (w_w_hitB) begin
            w_fwdB = i_resultW;
        end else begin
            w_fwdB = i_rd2E;
        end
    end
`else
    logic w_unused_fwd;

    // Without forwarding the register-file values are used directly.
    assign w_fwdA       = i_rd1E;
    assign w_fwdB       = i_rd2E;
    assign w_unused_fwd = ^{i_regwriteW, i_rdW, i_resultW, i_rs1E, i_rs2E};
`endif

    assign w_srcB = i_bselE ? i_imm_exE : w_fwdB;

    // ALU; unassigned select codes fall back to add.
    always_comb begin
        w_alu = w_fwdA + w_srcB;
        case (i_ALUselE)
            3'b000:  w_alu = w_fwdA + w_srcB;
            3'b001:  w_alu = w_fwdA - w_srcB;
            3'b010:  w_alu = w_fwdA & w_srcB;
            3'b011:  w_alu = w_fwdA | w_srcB;
            3'b100:  w_alu = w_fwdA ^ w_srcB;
            default: w_alu = w_fwdA + w_srcB;
        endcase
    end

    assign w_cond  = branch_cond(i_funct3E, i_brunE, w_fwdA, w_fwdB);
    assign w_pcsel = i_jumpE | (i_branchE & w_cond);

    // Redirect target: jalr uses rs1+imm with bit 0 cleared, jal/branches use pc+imm.
    always_comb begin
        w_target = {XLEN{1'b0}};
        if (!w_pcsel) begin
            w_target = {XLEN{1'b0}};
        end else if (i_jumpE && i_bselE) begin
            w_target = (w_fwdA + i_imm_exE) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            w_target = i_pcE + i_imm_exE;
        end
    end

    assign o_pcselE    = w_pcsel;
    assign o_pctargetE = w_target;

    // EX/MEM register: loads every cycle, store data always follows the rs2 path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwriteM  <= 1'b0;
            r_memrwM     <= 1'b0;
            r_wbselM     <= 2'b00;
            r_funct3M    <= 3'b000;
            r_rdM        <= 5'd0;
            r_aluresultM <= {XLEN{1'b0}};
            r_writedataM <= {XLEN{1'b0}};
            r_pc4M       <= RESET_PC4;
        end else begin
            r_regwriteM  <= i_regwriteE;
            r_memrwM     <= i_memrwE;
            r_wbselM     <= i_wbselE;
            r_funct3M    <= i_funct3E;
            r_rdM        <= i_rdE;
            r_aluresultM <= w_alu;
            r_writedataM <= w_fwdB;
            r_pc4M       <= i_pc4E;
        end
    end

    assign o_regwriteM  = r_regwriteM;
    assign o_memrwM     = r_memrwM;
    assign o_wbselM     = r_wbselM;
    assign o_funct3M    = r_funct3M;
    assign o_rdM        = r_rdM;
    assign o_aluresultM = r_aluresultM;
    assign o_writedataM = r_writedataM;
    assign o_pc4M       = r_pc4M;

endmodule

// File: tb/tb_execute.sv
// -----------------------------------------------------------------------------
// tb_execute : directed scoreboard bench for the execute stage.
// Each vector pushes its expected redirect (checked mid-cycle) and expected
// EX/MEM contents (checked after the next rising edge) into queues; two
// monitor processes pop and compare. Forwarding expectations follow the
// EXEC_FWD_EN build option.
// -----------------------------------------------------------------------------
module tb_execute;

`ifdef EXEC_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        regwriteE = 1'b0, memrwE = 1'b0, brunE = 1'b0;
    logic        branchE = 1'b0, jumpE = 1'b0, bselE = 1'b0;
    logic [1:0]  wbselE = 2'b00;
    logic [2:0]  ALUselE = 3'b000, funct3E = 3'b000;
    logic [4:0]  rdE = 5'd0, rs1E = 5'd0, rs2E = 5'd0;
    logic [31:0] rd1E = 32'd0, rd2E = 32'd0, imm_exE = 32'd0, pcE = 32'd0, pc4E = 32'd0;
    logic        regwriteW = 1'b0;
    logic [4:0]  rdW = 5'd0;
    logic [31:0] resultW = 32'd0;
    logic        pcselE;
    logic [31:0] pctargetE;
    logic        regwriteM, memrwM;
    logic [1:0]  wbselM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] aluresultM, writedataM, pc4M;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       nm;
        logic        pcsel;
        logic [31:0] tgt;
    } c_exp_t;

    typedef struct {
        string       nm;
        logic        rw;
        logic        mrw;
        logic [1:0]  wb;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } m_exp_t;

    c_exp_t q_c[$];
    m_exp_t q_m[$];

    execute #(.XLEN(32), .RESET_PC4(32'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_regwriteE(regwriteE), .i_memrwE(memrwE), .i_brunE(brunE),
        .i_branchE(branchE), .i_jumpE(jumpE), .i_bselE(bselE),
        .i_wbselE(wbselE), .i_ALUselE(ALUselE), .i_funct3E(funct3E),
        .i_rdE(rdE), .i_rs1E(rs1E), .i_rs2E(rs2E),
        .i_rd1E(rd1E), .i_rd2E(rd2E), .i_imm_exE(imm_exE), .i_pcE(pcE), .i_pc4E(pc4E),
        .i_regwriteW(regwriteW), .i_rdW(rdW), .i_resultW(resultW),
        .o_pcselE(pcselE), .o_pctargetE(pctargetE),
        .o_regwriteM(regwriteM), .o_memrwM(memrwM), .o_wbselM(wbselM),
        .o_funct3M(funct3M), .o_rdM(rdM),
        .o_aluresultM(aluresultM), .o_writedataM(writedataM), .o_pc4M(pc4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, ".regwriteM"},  {31'd0, regwriteM}, 32'd0);
        chk({tag, ".memrwM"},     {31'd0, memrwM},    32'd0);
        chk({tag, ".wbselM"},     {30'd0, wbselM},    32'd0);
        chk({tag, ".funct3M"},    {29'd0, funct3M},   32'd0);
        chk({tag, ".rdM"},        {27'd0, rdM},       32'd0);
        chk({tag, ".aluresultM"}, aluresultM,         32'd0);
        chk({tag, ".writedataM"}, writedataM,         32'd0);
        chk({tag, ".pc4M"},       pc4M,               32'd0);
    endtask

    // Issue one instruction at the falling edge and queue its expected results.
    task automatic op(input string nm,
                      input logic rw, input logic mrw, input logic brun,
                      input logic br, input logic jmp, input logic bsel,
                      input logic [1:0] wb, input logic [2:0] als, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [31:0] pc,
                      input logic ww, input logic [4:0] rdw, input logic [31:0] resw,
                      input logic [31:0] alu_f, input logic [31:0] alu_n,
                      input logic [31:0] wd_f, input logic [31:0] wd_n,
                      input logic ps, input logic [31:0] tgt);
        c_exp_t ce;
        m_exp_t me;
        @(negedge clk);
        regwriteE = rw;  memrwE = mrw;  brunE = brun;
        branchE = br;    jumpE = jmp;   bselE = bsel;
        wbselE = wb;     ALUselE = als; funct3E = f3;
        rdE = rd;        rs1E = rs1;    rs2E = rs2;
        rd1E = a;        rd2E = b;      imm_exE = imm;
        pcE = pc;        pc4E = pc + 32'd4;
        regwriteW = ww;  rdW = rdw;     resultW = resw;
        ce.nm = nm; ce.pcsel = ps; ce.tgt = tgt;
        me.nm = nm; me.rw = rw; me.mrw = mrw; me.wb = wb; me.f3 = f3; me.rd = rd;
        me.alu = FWD ? alu_f : alu_n;
        me.wd  = FWD ? wd_f : wd_n;
        me.pc4 = pc + 32'd4;
        q_c.push_back(ce);
        q_m.push_back(me);
    endtask

    // Redirect monitor: mid-cycle, after inputs and M registers have settled.
    initial begin
        c_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                chk({e.nm, ".pcselE"},    {31'd0, pcselE}, {31'd0, e.pcsel});
                chk({e.nm, ".pctargetE"}, pctargetE,       e.tgt);
            end
        end
    end

    // EX/MEM monitor: just after the edge that captured the instruction.
    initial begin
        m_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_m.size() > 0) begin
                e = q_m.pop_front();
                chk({e.nm, ".regwriteM"},  {31'd0, regwriteM}, {31'd0, e.rw});
                chk({e.nm, ".memrwM"},     {31'd0, memrwM},    {31'd0, e.mrw});
                chk({e.nm, ".wbselM"},     {30'd0, wbselM},    {30'd0, e.wb});
                chk({e.nm, ".funct3M"},    {29'd0, funct3M},   {29'd0, e.f3});
                chk({e.nm, ".rdM"},        {27'd0, rdM},       {27'd0, e.rd});
                chk({e.nm, ".aluresultM"}, aluresultM,         e.alu);
                chk({e.nm, ".writedataM"}, writedataM,         e.wd);
                chk({e.nm, ".pc4M"},       pc4M,               e.pc4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk_m_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        //  name            rw mrw brun br jmp bsel wb     als     f3      rd     rs1    rs2    rd1E          rd2E          imm           pc            ww   rdW    resultW       alu_f         alu_n         wd_f          wd_n          ps   tgt
        op("add",          1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,3'b000,5'd3, 5'd1, 5'd2, 32'd5,        32'd7,        32'd0,        32'h40,       1'b0,5'd0, 32'd0,        32'd12,       32'd12,       32'd7,        32'd7,        1'b0,32'd0);
        op("fwd_m_prio",   1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,3'b000,5'd4, 5'd3, 5'd0, 32'd1,        32'd2,        32'd0,        32'h44,       1'b1,5'd3, 32'd99,       32'd14,       32'd3,        32'd2,        32'd2,        1'b0,32'd0);
        op("fwd_w_and_m",  1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001,3'b000,5'd5, 5'd3, 5'd4, 32'd10,       32'd3,        32'd0,        32'h48,       1'b1,5'd3, 32'd99,       32'd85,       32'd7,        32'd14,       32'd3,        1'b0,32'd0);
        op("and_rd0",      1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,3'b000,5'd0, 5'd6, 5'd7, 32'h0000F0F0, 32'h00000FF0, 32'd0,        32'h4C,       1'b0,5'd0, 32'd0,        32'h000000F0, 32'h000000F0, 32'h00000FF0, 32'h00000FF0, 1'b0,32'd0);
        op("or_rs0",       1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b011,3'b000,5'd6, 5'd0, 5'd0, 32'd1,        32'd2,        32'd0,        32'h50,       1'b1,5'd0, 32'h77,       32'd3,        32'd3,        32'd2,        32'd2,        1'b0,32'd0);
        op("xor_imm_st",   1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,3'b100,3'b010,5'd7, 5'd6, 5'd6, 32'hFF,       32'h0F,       32'h0C,       32'h54,       1'b0,5'd0, 32'd0,        32'h0F,       32'hF3,       32'd3,        32'h0F,       1'b0,32'd0);
        op("blt_signed",   1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b100,5'd0, 5'd8, 5'd9, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      1'b0,5'd0, 32'd0,        32'd0,        32'd0,        32'd1,        32'd1,        1'b1,32'h120);
        op("bltu",         1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,3'b000,3'b100,5'd0, 5'd8, 5'd9, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      1'b0,5'd0, 32'd0,        32'd0,        32'd0,        32'd1,        32'd1,        1'b0,32'd0);
        op("bge_equal",    1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b101,5'd0, 5'd8, 5'd9, 32'd5,        32'd5,        32'hFFFFFFF0, 32'h200,      1'b0,5'd0, 32'd0,        32'd10,       32'd10,       32'd5,        32'd5,        1'b1,32'h1F0);
        op("bge_s_nt",     1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b101,5'd0, 5'd8, 5'd9, 32'hFFFFFFFF, 32'd1,        32'd8,        32'h300,      1'b0,5'd0, 32'd0,        32'd0,        32'd0,        32'd1,        32'd1,        1'b0,32'd0);
        op("bgeu_t",       1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,3'b000,3'b101,5'd0, 5'd8, 5'd9, 32'hFFFFFFFF, 32'd1,        32'd8,        32'h300,      1'b0,5'd0, 32'd0,        32'd0,        32'd0,        32'd1,        32'd1,        1'b1,32'h308);
        op("beq_nt",       1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b000,5'd0, 5'd8, 5'd9, 32'd3,        32'd4,        32'd8,        32'h300,      1'b0,5'd0, 32'd0,        32'd7,        32'd7,        32'd4,        32'd4,        1'b0,32'd0);
        op("bne_t",        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b001,5'd0, 5'd8, 5'd9, 32'd3,        32'd4,        32'd8,        32'h300,      1'b0,5'd0, 32'd0,        32'd7,        32'd7,        32'd4,        32'd4,        1'b1,32'h308);
        op("br_f3_010",    1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b010,5'd0, 5'd8, 5'd9, 32'd1,        32'd2,        32'd8,        32'h300,      1'b0,5'd0, 32'd0,        32'd3,        32'd3,        32'd2,        32'd2,        1'b0,32'd0);
        op("jalr",         1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,2'b10,3'b000,3'b000,5'd1, 5'd10,5'd11,32'h203,      32'd9,        32'd4,        32'h400,      1'b0,5'd0, 32'd0,        32'h207,      32'h207,      32'd9,        32'd9,        1'b1,32'h206);
        op("fwd_pc4",      1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,3'b000,5'd2, 5'd1, 5'd0, 32'd0,        32'd0,        32'd0,        32'h404,      1'b0,5'd0, 32'd0,        32'h404,      32'd0,        32'd0,        32'd0,        1'b0,32'd0);
        op("jal",          1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,3'b000,5'd0, 5'd0, 5'd0, 32'd1,        32'd1,        32'h10,       32'h500,      1'b0,5'd0, 32'd0,        32'd2,        32'd2,        32'd1,        32'd1,        1'b1,32'h510);
        op("load",         1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,3'b010,5'd5, 5'd11,5'd0, 32'h1000,     32'd0,        32'd4,        32'h504,      1'b0,5'd0, 32'd0,        32'h1004,     32'h1004,     32'd0,        32'd0,        1'b0,32'd0);
        op("load_m_w_hit", 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b010,5'd5, 5'd5, 5'd12,32'h10,       32'h20,       32'd0,        32'h508,      1'b1,5'd5, 32'h33,       32'h53,       32'h30,       32'h20,       32'h20,       1'b0,32'd0);
        op("load_m_no_w",  1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,3'b000,5'd13,5'd5, 5'd0, 32'd7,        32'd1,        32'd0,        32'h50C,      1'b0,5'd0, 32'd0,        32'd8,        32'd8,        32'd1,        32'd1,        1'b0,32'd0);
        op("sub_wrap",     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001,3'b000,5'd14,5'd0, 5'd0, 32'd0,        32'd1,        32'd0,        32'h510,      1'b0,5'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0,32'd0);
        op("alusel_undef", 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b111,3'b000,5'd15,5'd0, 5'd0, 32'd2,        32'd3,        32'd0,        32'h514,      1'b0,5'd0, 32'd0,        32'd5,        32'd5,        32'd3,        32'd3,        1'b0,32'd0);
        op("bubble",       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,5'd0, 5'd0, 5'd0, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFC, 1'b0,5'd0, 32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        1'b0,32'd0);
        op("pre_reset",    1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,3'b000,5'd9, 5'd0, 5'd0, 32'h50,       32'd5,        32'd0,        32'h600,      1'b0,5'd0, 32'd0,        32'h55,       32'h55,       32'd5,        32'd5,        1'b0,32'd0);

        // Let the monitors drain, bounded.
        for (int i = 0; i < 20 && (q_c.size() != 0 || q_m.size() != 0); i++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (q_c.size() != 0 || q_m.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", q_c.size(), q_m.size());
        end

        // Mid-stream async reset with aluresultM holding 0x55.
        rst_n = 1'b0;
        #1;
        chk_m_zero("reset_async");
        @(posedge clk);
        #1;
        chk_m_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_release.aluresultM", aluresultM, 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
